// File: rtl/bus_arbiter_8_pkg.sv
// Shared definitions for the 8-master round-robin bus arbiter: FSM encoding,
// sizing constants and the one-hot decode helper.
package bus_arbiter_8_pkg;

  localparam int N_MASTERS = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  function automatic logic [N_MASTERS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_MASTERS-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage : bus_arbiter_8_pkg

// File: rtl/bus_arbiter_8_if.sv
// Request/grant bundle between the bus requesters (master side) and the
// arbiter (slave side).
interface bus_arbiter_8_if;
  import bus_arbiter_8_pkg::*;

  logic [N_MASTERS-1:0] req;
  logic                 done;
  logic                 gnt_valid;
  logic [IDX_W-1:0]     gnt_idx;
  logic [N_MASTERS-1:0] gnt_onehot;
  logic                 timeout;

  // req is a level: a master keeps it high until it no longer wants the bus.
  // done is a one-cycle release strobe that only means something to the
  // current owner while a grant is active; grants are valid whenever
  // gnt_valid is high and carry no ready/acknowledge.
  modport master (
    output req,
    output done,
    input  gnt_valid,
    input  gnt_idx,
    input  gnt_onehot,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt_valid,
    output gnt_idx,
    output gnt_onehot,
    output timeout
  );

endinterface : bus_arbiter_8_if

// File: rtl/bus_arbiter_8_rr_pick_8.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo 8.
module rr_pick_8
  import bus_arbiter_8_pkg::*;
(
  input  logic [N_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 any,
  output logic [IDX_W-1:0]     idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    any   = |req;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      // 3-bit addition wraps naturally, giving the ptr..ptr+7 scan order.
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule : rr_pick_8

// File: rtl/bus_arbiter_8.sv
// Round-robin owner arbiter for the shared 8-bit internal bus with one
// turnaround cycle per release. Optional forced release: ARB_TIMEOUT_EN.
module bus_arbiter_8
  import bus_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  bus_arbiter_8_if.slave   bus,
  output state_e           dbg_state,
  output logic [IDX_W-1:0] dbg_ptr
);

  if ((MAX_HOLD < 1) || (MAX_HOLD > 31) || ((1 << HOLD_W) <= MAX_HOLD)) begin : g_param_check
    $error("bus_arbiter_8: MAX_HOLD/HOLD_W out of range");
  end

  state_e               state, state_n;
  logic [IDX_W-1:0]     ptr, ptr_n;
  logic                 valid_q, valid_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic [N_MASTERS-1:0] onehot_q, onehot_n;
  logic                 timeout_q, timeout_n;

  logic                 pick_any;
  logic [IDX_W-1:0]     pick_idx;
  logic                 release_now;

  rr_pick_8 u_pick (
    .req (bus.req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // In GRANT idx_q is the owner, so its own request line decides release.
  assign release_now = bus.done | ~bus.req[idx_q];

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else        hold_cnt <= hold_cnt_n;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      onehot_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      valid_q   <= valid_n;
      idx_q     <= idx_n;
      onehot_q  <= onehot_n;
      timeout_q <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    valid_n   = 1'b0;
    idx_n     = '0;
    timeout_n = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_n = hold_cnt;
`endif
    unique case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_n = ST_GRANT;
          valid_n = 1'b1;
          idx_n   = pick_idx;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_n = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          state_n = ST_TURN;
          ptr_n   = idx_q + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
        end else if (hold_cnt == HOLD_LAST) begin
          // A normal release above wins; only a still-held grant is revoked.
          state_n   = ST_TURN;
          ptr_n     = idx_q + IDX_W'(1);
          timeout_n = 1'b1;
`endif
        end else begin
          valid_n = 1'b1;
          idx_n   = idx_q;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_n = hold_cnt + HOLD_W'(1);
`endif
        end
      end
      ST_TURN: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    // Decoding the next idx keeps the one-hot in lockstep with gnt_idx.
    onehot_n = valid_n ? idx_to_onehot(idx_n) : '0;
  end

  assign bus.gnt_valid  = valid_q;
  assign bus.gnt_idx    = idx_q;
  assign bus.gnt_onehot = onehot_q;
  assign bus.timeout    = timeout_q;
  assign dbg_state      = state;
  assign dbg_ptr        = ptr;

endmodule : bus_arbiter_8

// File: tb/tb_bus_arbiter_8.sv
// Directed bench for bus_arbiter_8; expected values are hand-computed per vector.
// Build with +define+ARB_TIMEOUT_EN to exercise the forced-release path.
module tb_bus_arbiter_8;
  import bus_arbiter_8_pkg::*;

  logic       clk;
  logic       rst_n;
  state_e     dbg_state;
  logic [2:0] dbg_ptr;
  int         n_checks;
  int         n_fail;

  bus_arbiter_8_if bus ();

  bus_arbiter_8 #(.MAX_HOLD(4), .HOLD_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [2:0] idx);
    logic [7:0] oh;
    oh = 8'h01 << idx;
    check_eq({tag, "_valid"}, 32'(bus.gnt_valid), 32'd1);
    check_eq({tag, "_idx"}, 32'(bus.gnt_idx), 32'(idx));
    check_eq({tag, "_onehot"}, 32'(bus.gnt_onehot), 32'(oh));
    check_eq({tag, "_state"}, 32'(dbg_state), 32'(ST_GRANT));
  endtask

  task automatic check_idle_bus(input string tag, input state_e st);
    check_eq({tag, "_valid"}, 32'(bus.gnt_valid), 32'd0);
    check_eq({tag, "_idx"}, 32'(bus.gnt_idx), 32'd0);
    check_eq({tag, "_onehot"}, 32'(bus.gnt_onehot), 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'(st));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    apply_reset();

    // 1: idle with no requests
    for (int i = 0; i < 5; i++) begin
      check_idle_bus("t1_idle", ST_IDLE);
      check_eq("t1_timeout", 32'(bus.timeout), 32'd0);
      check_eq("t1_ptr", 32'(dbg_ptr), 32'd0);
      tick();
    end

    // 2: single requester 2, done pulse in cycle 3
    bus.req = 8'h04;
    tick();
    check_grant("t2_c1", 3'd2);
    tick();
    check_grant("t2_c2", 3'd2);
    tick();
    check_grant("t2_c3", 3'd2);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 8'h00;
    check_idle_bus("t2_turn", ST_TURN);
    check_eq("t2_ptr", 32'(dbg_ptr), 32'd3);
    tick();
    check_idle_bus("t2_back_idle", ST_IDLE);

    // done outside GRANT has no effect
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check_idle_bus("t2_done_idle", ST_IDLE);
    check_eq("t2_ptr_kept", 32'(dbg_ptr), 32'd3);

    // 3: all requesting, rotation 0..7,0 from ptr 0
    apply_reset();
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      check_grant($sformatf("t3_g%0d", k), 3'(k % 8));
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      check_idle_bus($sformatf("t3_turn%0d", k), ST_TURN);
      check_eq($sformatf("t3_ptr%0d", k), 32'(dbg_ptr), 32'((k + 1) % 8));
      tick();
      check_idle_bus($sformatf("t3_idle%0d", k), ST_IDLE);
    end
    bus.req = 8'h00;
    tick();
    check_eq("t3_ptr_end", 32'(dbg_ptr), 32'd1);

    // 4: steer ptr to 6 via owner 5, then 0x41 -> 6, then wrap to 0
    bus.req = 8'h20;
    tick();
    check_grant("t4_g5", 3'd5);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 8'h41;
    check_eq("t4_ptr6", 32'(dbg_ptr), 32'd6);
    tick();
    tick();
    check_grant("t4_g6", 3'd6);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check_eq("t4_ptr7", 32'(dbg_ptr), 32'd7);
    tick();
    tick();
    check_grant("t4_wrap0", 3'd0);
    // release by dropping the owner's request
    bus.req = 8'h40;
    tick();
    check_idle_bus("t4_reqdrop_turn", ST_TURN);
    check_eq("t4_ptr1", 32'(dbg_ptr), 32'd1);
    bus.req = 8'h00;
    tick();
    tick();
    check_idle_bus("t4_idle", ST_IDLE);

    // 5: sole requester 0 never releases
    bus.req = 8'h01;
    tick();
    check_grant("t5_g0", 3'd0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check_grant($sformatf("t5_hold%0d", i), 3'd0);
      check_eq($sformatf("t5_to_low%0d", i), 32'(bus.timeout), 32'd0);
    end
    tick();
    check_idle_bus("t5_revoke", ST_TURN);
    check_eq("t5_timeout_pulse", 32'(bus.timeout), 32'd1);
    check_eq("t5_ptr", 32'(dbg_ptr), 32'd1);
    tick();
    check_idle_bus("t5_idle", ST_IDLE);
    check_eq("t5_timeout_clear", 32'(bus.timeout), 32'd0);
    tick();
    check_grant("t5_regrant", 3'd0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check_grant($sformatf("t5_hold%0d", i), 3'd0);
      check_eq($sformatf("t5_to_low%0d", i), 32'(bus.timeout), 32'd0);
    end
`endif
    bus.req = 8'h00;
    tick();
    check_idle_bus("t5_turn", ST_TURN);
    check_eq("t5_ptr_end", 32'(dbg_ptr), 32'd1);
    tick();

    // 6: async reset in the middle of a grant to owner 5
    bus.req = 8'h20;
    tick();
    check_grant("t6_g5", 3'd5);
    tick();
    rst_n = 1'b0;
    #1;
    check_idle_bus("t6_async", ST_IDLE);
    check_eq("t6_ptr_rst", 32'(dbg_ptr), 32'd0);
    tick();
    check_idle_bus("t6_no_turn", ST_IDLE);
    rst_n = 1'b1;
    tick();
    check_grant("t6_regrant5", 3'd5);
    check_eq("t6_ptr0", 32'(dbg_ptr), 32'd0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 8'h00;
    check_idle_bus("t6_turn", ST_TURN);
    check_eq("t6_ptr6", 32'(dbg_ptr), 32'd6);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bus_arbiter_8
